// File: rtl/simple_pipe_pkg.sv
// Shared defaults and the per-lane state-update function for simple_pipe.
package simple_pipe_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 3;
    localparam bit INVERT_DEF = 1'b1;

    // Lane update: the flop sets only when both operands are high and it was low.
    function automatic logic lane_f(input logic a, input logic b, input logic q);
        return a & b & ~q;
    endfunction

endpackage

// File: rtl/simple_pipe_if.sv
// Handshake bundle between simple_pipe and its producer/consumer.
interface simple_pipe_if
    import simple_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inp1;
    logic [WIDTH-1:0] inp2;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] state_q;

    modport master (
        output in_valid, inp1, inp2, clear, out_ready,
        input  in_ready, out_valid, out, state_q
    );

    modport slave (
        input  in_valid, inp1, inp2, clear, out_ready,
        output in_ready, out_valid, out, state_q
    );
endinterface

// File: rtl/simple_pipe_stage.sv
// One elastic register stage: captures the upstream word whenever it advances.
module simple_pipe_stage
    import simple_pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             v_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             adv_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Next state: on advance take the upstream valid; data is only captured with a valid word.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (adv_i) begin
            v_d = v_i;
            if (v_i) begin
                d_d = d_i;
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/simple_pipe.sv
// WIDTH-lane feedback-flop array feeding a DEPTH-stage valid/ready output pipeline.
module simple_pipe
    import simple_pipe_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter bit INVERT_OUT = INVERT_DEF
) (
    input  logic         tau2015_clk,
    input  logic         rst,
    simple_pipe_if.slave bus
);

    logic [WIDTH-1:0] lane_q, lane_d;
    logic [WIDTH-1:0] q_base;
    logic [WIDTH-1:0] q_new;
    logic [WIDTH-1:0] word;
    logic             in_ready_w;
    logic             acc;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];

    // A stage may advance when it or any stage downstream of it has room, or the sink pops.
    // Written as a reduction over the valid vector so the chain has no self-referencing net.
    for (genvar g = 0; g < DEPTH; g++) begin : g_adv
        assign adv[g] = bus.out_ready | ~(&v[DEPTH-1:g]);
    end

    assign in_ready_w = adv[0] & ~rst;
    assign acc        = bus.in_valid & in_ready_w;

    // Lane update; a simultaneous clear zeroes the old state before the accept uses it.
    always_comb begin
        q_base = bus.clear ? '0 : lane_q;
        q_new  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            q_new[k] = lane_f(bus.inp1[k], bus.inp2[k], q_base[k]);
        end
        word = INVERT_OUT ? ~q_new : q_new;
        if (acc) begin
            lane_d = q_new;
        end else if (bus.clear) begin
            lane_d = '0;
        end else begin
            lane_d = lane_q;
        end
    end

    // Lane state register; reset wins over clear and accept.
    always_ff @(posedge tau2015_clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_first
            simple_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i (tau2015_clk),
                .rst_i (rst),
                .v_i   (acc),
                .d_i   (word),
                .adv_i (adv[g]),
                .v_o   (v[g]),
                .d_o   (d[g])
            );
        end else begin : g_rest
            simple_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i (tau2015_clk),
                .rst_i (rst),
                .v_i   (v[g-1]),
                .d_i   (d[g-1]),
                .adv_i (adv[g]),
                .v_o   (v[g]),
                .d_o   (d[g])
            );
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out       = d[DEPTH-1];
    assign bus.state_q   = lane_q;

endmodule

// File: tb/tb_simple_pipe.sv
// Directed bench: one inverting and one non-inverting instance share every input.
module tb_simple_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       clear;
    logic       out_ready;
    logic [3:0] inp1;
    logic [3:0] inp2;

    int total;
    int bad;

    simple_pipe_if #(.WIDTH(4)) bus_i ();
    simple_pipe_if #(.WIDTH(4)) bus_n ();

    assign bus_i.in_valid  = in_valid;
    assign bus_i.clear     = clear;
    assign bus_i.out_ready = out_ready;
    assign bus_i.inp1      = inp1;
    assign bus_i.inp2      = inp2;
    assign bus_n.in_valid  = in_valid;
    assign bus_n.clear     = clear;
    assign bus_n.out_ready = out_ready;
    assign bus_n.inp1      = inp1;
    assign bus_n.inp2      = inp2;

    simple_pipe #(.WIDTH(4), .DEPTH(3), .INVERT_OUT(1'b1)) dut_i (
        .tau2015_clk (clk),
        .rst         (rst),
        .bus         (bus_i.slave)
    );

    simple_pipe #(.WIDTH(4), .DEPTH(3), .INVERT_OUT(1'b0)) dut_n (
        .tau2015_clk (clk),
        .rst         (rst),
        .bus         (bus_n.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       vld;
        logic       clr;
        logic       ordy;
        logic [3:0] a;
        logic [3:0] b;
        logic       e_rdy;
        logic       e_ov;
        logic       c_out;
        logic [3:0] e_q;
        logic [3:0] e_out;
        logic [3:0] e_out_n;
    } vec_t;

    vec_t vt [20];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic c, input logic o,
                         input logic [3:0] a, input logic [3:0] b);
        rst       = r;
        in_valid  = v;
        clear     = c;
        out_ready = o;
        inp1      = a;
        inp2      = b;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_q(input string name, input logic [3:0] exp);
        chk4({name, "_q_inv"}, bus_i.state_q, exp);
        chk4({name, "_q_pos"}, bus_n.state_q, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        apply(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);

        //          rst   vld   clr   ordy  a     b       rdy   ov    cout  q     out   out_n
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF,  1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF,  1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 4'h0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h5,  1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b1, 1'b1, 4'h5, 4'hA, 4'h5};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h5,  1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h5,  1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h5,  1'b1, 1'b1, 1'b1, 4'h5, 4'hA, 4'h5};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b1, 1'b1, 4'h5, 4'hF, 4'h0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b1, 1'b1, 4'h5, 4'hA, 4'h5};
        vt[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h0};
        vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF,  1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0};
        vt[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF};
        vt[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0,  1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 4'h0};

        // Reset, single accept latency, clear alone, streaming and clear-with-accept.
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vt[i].rst, vt[i].vld, vt[i].clr, vt[i].ordy, vt[i].a, vt[i].b);
            chk1({tag, "_rdy_inv"}, bus_i.in_ready, vt[i].e_rdy);
            chk1({tag, "_rdy_pos"}, bus_n.in_ready, vt[i].e_rdy);
            tick();
            chk_q(tag, vt[i].e_q);
            chk1({tag, "_ov_inv"}, bus_i.out_valid, vt[i].e_ov);
            chk1({tag, "_ov_pos"}, bus_n.out_valid, vt[i].e_ov);
            if (vt[i].c_out) begin
                chk4({tag, "_out_inv"}, bus_i.out, vt[i].e_out);
                chk4({tag, "_out_pos"}, bus_n.out, vt[i].e_out_n);
            end
        end

        // Backpressure: three words fill the pipe, further offers stall without touching q.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        tick();
        chk_q("bp_clr", 4'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h1);
        chk1("bp_w1_rdy", bus_i.in_ready, 1'b1);
        tick();
        chk_q("bp_w1", 4'h1);
        chk1("bp_w1_ov", bus_i.out_valid, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h2);
        chk1("bp_w2_rdy", bus_i.in_ready, 1'b1);
        tick();
        chk_q("bp_w2", 4'h2);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h4);
        chk1("bp_w3_rdy", bus_i.in_ready, 1'b1);
        tick();
        chk_q("bp_w3", 4'h4);
        chk1("bp_w3_ov", bus_i.out_valid, 1'b1);
        chk4("bp_w3_out", bus_i.out, 4'hE);
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h8);
            chk1($sformatf("bp_full%0d_rdy", k), bus_i.in_ready, 1'b0);
            tick();
            chk_q($sformatf("bp_full%0d", k), 4'h4);
            chk1($sformatf("bp_full%0d_ov", k), bus_i.out_valid, 1'b1);
            chk4($sformatf("bp_full%0d_out", k), bus_i.out, 4'hE);
        end
        apply(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h8);
        chk1("bp_pushpop_rdy", bus_i.in_ready, 1'b1);
        tick();
        chk_q("bp_pushpop", 4'h8);
        chk1("bp_pop1_ov", bus_i.out_valid, 1'b1);
        chk4("bp_pop1_out", bus_i.out, 4'hD);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        tick();
        chk1("bp_pop2_ov", bus_i.out_valid, 1'b1);
        chk4("bp_pop2_out", bus_i.out, 4'hB);
        chk4("bp_pop2_out_pos", bus_n.out, 4'h4);
        tick();
        chk1("bp_pop3_ov", bus_i.out_valid, 1'b1);
        chk4("bp_pop3_out", bus_i.out, 4'h7);
        tick();
        chk1("bp_empty_ov", bus_i.out_valid, 1'b0);
        chk_q("bp_end", 4'h8);

        // Reset with a full pipe discards everything in flight.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF);
        tick();
        chk_q("rs_w1", 4'h7);
        tick();
        chk_q("rs_w2", 4'h8);
        tick();
        chk_q("rs_w3", 4'h7);
        chk1("rs_full_ov", bus_i.out_valid, 1'b1);
        chk1("rs_full_rdy", bus_i.in_ready, 1'b0);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        chk1("rs_rdy_in_rst", bus_i.in_ready, 1'b0);
        tick();
        chk1("rs_ov", bus_i.out_valid, 1'b0);
        chk4("rs_out", bus_i.out, 4'h0);
        chk_q("rs", 4'h0);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        chk1("rs_rel_rdy", bus_i.in_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1($sformatf("rs_post%0d_ov_inv", k), bus_i.out_valid, 1'b0);
            chk1($sformatf("rs_post%0d_ov_pos", k), bus_n.out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
